// File: rtl/tile_scroll_controller.sv
// Tile-map lookup and horizontal scroll sequencer for the 16x16 sprite datapath.
// One single-port map RAM is shared between the pixel lookup, the host writes and the clear sweep.
module tile_scroll_controller #(
    parameter int unsigned TILE_W    = 16,
    parameter int unsigned TILE_H    = 16,
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 45,
    parameter int unsigned H_ACTIVE  = 1280,
    parameter int unsigned V_ACTIVE  = 720,
    parameter int unsigned EMPTY_IDX = 63
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        new_frame_in,
    input  logic        scroll_en_in,
    input  logic [3:0]  scroll_speed_in,
    input  logic        map_wr_valid_in,
    input  logic [11:0] map_wr_addr_in,
    input  logic [5:0]  map_wr_data_in,
    output logic        map_wr_ready_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [5:0]  unique_image_index,
    output logic        in_sprite,
    output logic [11:0] offset_out,
    output logic        clear_busy_out
);

    localparam int unsigned Depth      = COLS * ROWS;
    localparam int unsigned TileWShift = $clog2(TILE_W);
    localparam int unsigned TileHShift = $clog2(TILE_H);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StRun   = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [11:0] clear_addr_q, clear_addr_d;
    logic [11:0] offset_q, offset_d;
    logic [11:0] offset_sum;

    logic        active_in;
    logic [11:0] hx_sum, hx, col_idx, row_idx, lookup_addr;
    logic        wr_ready, wr_fire, wr_in_range;

    logic        ram_we;
    logic [11:0] ram_addr;
    logic [5:0]  ram_wdata;
    logic [5:0]  ram_rd_q;
    logic [5:0]  mem [Depth];

    logic [10:0] hcount_s1_q, hcount_q;
    logic [9:0]  vcount_s1_q, vcount_q;
    logic        active_s1_q;
    logic [5:0]  index_q;
    logic        in_sprite_q;

    always_comb begin
        active_in   = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
        hx_sum      = {1'b0, hcount_in} + offset_q;
        hx          = (hx_sum >= 12'(H_ACTIVE)) ? hx_sum - 12'(H_ACTIVE) : hx_sum;
        col_idx     = hx >> TileWShift;
        row_idx     = {2'b00, vcount_in} >> TileHShift;
        // Gate to 0 outside the active area so the read address never leaves the map.
        lookup_addr = ((state_q == StRun) && active_in) ? row_idx * 12'(COLS) + col_idx : 12'd0;

        wr_ready    = (state_q == StRun) && !active_in;
        wr_fire     = map_wr_valid_in && wr_ready;
        wr_in_range = map_wr_addr_in < 12'(Depth);
    end

    // Single RAM port: clear sweep, then accepted in-range host write, else pixel lookup.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = lookup_addr;
        ram_wdata = map_wr_data_in;
        if (state_q == StClear) begin
            ram_we    = 1'b1;
            ram_addr  = clear_addr_q;
            ram_wdata = 6'(EMPTY_IDX);
        end else if (wr_fire && wr_in_range) begin
            ram_we   = 1'b1;
            ram_addr = map_wr_addr_in;
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        offset_d     = offset_q;
        offset_sum   = offset_q + {8'd0, scroll_speed_in};
        case (state_q)
            StClear: begin
                if (clear_addr_q == 12'(Depth - 1)) begin
                    state_d      = StRun;
                    clear_addr_d = 12'd0;
                end else begin
                    clear_addr_d = clear_addr_q + 12'd1;
                end
            end
            default: begin
                if (new_frame_in && scroll_en_in) begin
                    offset_d = (offset_sum >= 12'(H_ACTIVE)) ? offset_sum - 12'(H_ACTIVE)
                                                             : offset_sum;
                end
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end else begin
            ram_rd_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q      <= StClear;
            clear_addr_q <= 12'd0;
            offset_q     <= 12'd0;
            hcount_s1_q  <= 11'd0;
            vcount_s1_q  <= 10'd0;
            active_s1_q  <= 1'b0;
            hcount_q     <= 11'd0;
            vcount_q     <= 10'd0;
            index_q      <= 6'd0;
            in_sprite_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
            offset_q     <= offset_d;
            hcount_s1_q  <= hcount_in;
            vcount_s1_q  <= vcount_in;
            active_s1_q  <= (state_q == StRun) && active_in;
            hcount_q     <= hcount_s1_q;
            vcount_q     <= vcount_s1_q;
            index_q      <= active_s1_q ? ram_rd_q : 6'd0;
            in_sprite_q  <= active_s1_q && (ram_rd_q != 6'(EMPTY_IDX));
        end
    end

    assign map_wr_ready_out   = wr_ready;
    assign hcount_out         = hcount_q;
    assign vcount_out         = vcount_q;
    assign unique_image_index = index_q;
    assign in_sprite          = in_sprite_q;
    assign offset_out         = offset_q;
    assign clear_busy_out     = (state_q == StClear);

endmodule
